rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters.
- Grants exactly one requester at a time and drives the mux select pair {s0,s1} to that requester's index.
- Registers the selected data bit with a valid flag.
- Sits between the lab's requester logic and the behavioural 4:1 mux; the select encoding matches the mux case order: {s0,s1} = 00 selects i0, 01 selects i1, 10 selects i2, 11 selects i3.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one requester may hold a grant before forced rotation. Legal range 1..255. Counter width is clog2(HOLD_MAX+1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-high reset; one clock domain only
- req  input  4  request vector, bit n = requester n; level-sensitive, held high while access is wanted
- din  input  4  data bits, din[n] routed to mux input i<n>
- gnt  output  4  one-hot grant, registered; all-zero when idle
- s0  output  1  mux select MSB, registered
- s1  output  1  mux select LSB, registered
- busy  output  1  high while any grant is active (equals |gnt)
- d  output  1  registered mux output: din[granted index] sampled one cycle after the grant
- d_valid  output  1  high when d holds data from a granted cycle

Behaviour:
- Reset (asserted at any time, including mid-grant) immediately clears all state and outputs:
  - gnt=0000, s0=0, s1=0, busy=0, d=0, d_valid=0
  - priority pointer ptr=0, hold counter cnt=0, state=IDLE
- States: IDLE, GRANT.
- IDLE:
  - If req==0000, stay in IDLE; outputs hold their reset values, except that d_valid drops one cycle after the last grant.
  - If any req bit is set, on the next rising edge grant the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - That edge sets gnt one-hot, sets {s0,s1} to the binary index, sets cnt=1 and moves to GRANT.
  - Latency from req rising to gnt is one cycle.
- GRANT, holder index h:
  - Continue when req[h]=1 and cnt<HOLD_MAX: keep gnt and select, cnt<=cnt+1.
  - Release when req[h]=0, or when cnt==HOLD_MAX, checked on the same edge. The pointer updates to ptr<=h+1 (mod 4).
  - On release, search from h+1. If another requester is set, hand off directly on the same edge; there is no idle bubble.
  - The search includes h last. A timed-out holder that is still requesting, with no competitor, is re-granted with cnt=1.
  - If no request remains, clear gnt/select/busy and return to IDLE.
- Select and gnt always change together on the same edge. s0/s1 are never changed without gnt changing.
- Data path:
  - Each edge, d<=din[index of current gnt] and d_valid<=|gnt.
  - If gnt==0000, then d<=0 and d_valid<=0.
  - d therefore lags the grant by one cycle.
- Requests from non-holders are ignored until a release. Glitches on those bits while a grant is active have no effect.
- HOLD_MAX=1: the grant is re-arbitrated every cycle, giving pure round-robin per cycle.
- Counter saturation: cnt never exceeds HOLD_MAX. Wrap of ptr from 3 goes to 0.
- Simultaneous release and new request of the same requester: treated as release. That requester competes in the next search at lowest priority.

Decomposition:
- Shared header/package holds:
  - state encodings IDLE=1'b0, GRANT=1'b1
  - NUM_REQ=4 and SEL_W=2 constants
  - the select-pair encoding {s0,s1} <-> index
- One combinational sub-module rr_pick4:
  - inputs: req[3:0], start index [1:0]
  - outputs: found, index[1:0]
  - instantiated once for the arbitration search.
- The FSM, counter and data register stay in rr_mux_arbiter.

Test Plan:
- Reset mid-grant:
  - Stimulus: holder 2 active, cnt=3, assert reset between clock edges.
  - Response: gnt=0000, s0=s1=0, d_valid=0 immediately without a clock edge; after reset releases, req=0100 is granted again after one edge.
- Single requester:
  - Stimulus: req=0010 from idle.
  - Response: gnt=0010, {s0,s1}=01 after one edge; d=din[1] with d_valid=1 one edge later; dropping req gives gnt=0000 next edge.
- Round-robin fairness:
  - Stimulus: req=1111 held, HOLD_MAX=2.
  - Response: grants 0001,0001,0010,0010,0100,0100,1000,1000,0001 on successive edges with no idle cycles.
- Timeout re-grant:
  - Stimulus: HOLD_MAX=3, only req[3] high for 8 cycles.
  - Response: gnt=1000 continuously; cnt sequence 1,2,3,1,2,3,...; busy never drops.
- Handoff on release:
  - Stimulus: holder 1 drops req on the same edge req[0] and req[3] are high.
  - Response: next gnt=1000, because the search from index 2 finds 3 before 0; {s0,s1}=11.
- Data mapping:
  - Stimulus: din=1010, each requester granted in turn.
  - Response: d sequence 0,1,0,1 for indices 0..3, each one cycle after its grant.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter_pkg
//   Shared definitions for the round-robin 4:1 mux arbiter:
//     - FSM state encoding (IDLE / GRANT)
//     - requester count and select width
//     - the mux select pair {s0,s1} and its mapping to/from a requester index
//   {s0,s1} = 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3 (s0 is the MSB).
// ---------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef logic [SEL_W-1:0]   idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Mux select pair exactly as the downstream 4:1 mux sees it.
  typedef struct packed {
    logic s0;  // MSB of the index
    logic s1;  // LSB of the index
  } sel_t;

  function automatic sel_t idx_to_sel(input idx_t idx);
    sel_t sel;
    sel.s0 = idx[1];
    sel.s1 = idx[0];
    return sel;
  endfunction

  function automatic idx_t sel_to_idx(input sel_t sel);
    return {sel.s0, sel.s1};
  endfunction

  function automatic req_vec_t idx_to_onehot(input idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
//   Combinational round-robin search over four request bits.
//   Scans start, start+1, start+2, start+3 (mod 4) and reports the first set
//   bit.
//   Ports:
//     req   [3:0] in  request vector
//     start [1:0] in  index with highest priority
//     found       out at least one request bit is set
//     index [1:0] out first set bit in search order (start when none found)
// ---------------------------------------------------------------------------
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  req_vec_t req,
  input  idx_t     start,
  output logic     found,
  output idx_t     index
);

  idx_t cand;

  // Walk from lowest to highest priority so the highest-priority hit is the
  // last assignment and wins.
  // NOTE: every output and temporary is given a default before the loop so
  // no path leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    found = 1'b0;
    index = start;
    cand  = start;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + idx_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter sharing one 4:1 single-bit mux among four requesters.
//   A requester keeps the grant while it requests, for at most HOLD_MAX
//   consecutive cycles; on release the next requester after the holder is
//   granted on the same edge (the holder itself is searched last).
//   The selected data bit is registered one cycle after the grant.
//   Ports:
//     clk          in  system clock, rising edge
//     reset        in  asynchronous active-high reset
//     req   [3:0]  in  level request vector, bit n = requester n
//     din   [3:0]  in  data bits, din[n] routed to mux input i<n>
//     gnt   [3:0]  out one-hot registered grant, zero when idle
//     s0, s1       out registered mux select pair {s0,s1} = granted index
//     busy         out |gnt
//     d            out din[granted index], one cycle after the grant
//     d_valid      out d carries data from a granted cycle
// ---------------------------------------------------------------------------
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8  // legal range 1..255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               busy,
  output logic               d,
  output logic               d_valid
);

  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  idx_t             ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  req_vec_t         gnt_nxt;
  sel_t             sel, sel_nxt;

  idx_t holder;
  idx_t search_start;
  logic pick_found;
  idx_t pick_index;

  // The select register doubles as the holder index, so gnt and select can
  // never disagree.
  assign holder = sel_to_idx(sel);

  // From IDLE search from the pointer; on release search from the holder's
  // successor, which puts the holder itself last.
  assign search_start = (state == IDLE) ? ptr : holder + idx_t'(1);

  rr_pick4 u_pick (
    .req   (req),
    .start (search_start),
    .found (pick_found),
    .index (pick_index)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          gnt_nxt   = idx_to_onehot(pick_index);
          sel_nxt   = idx_to_sel(pick_index);
          cnt_nxt   = CNT_ONE;
        end
      end
      GRANT: begin
        if (req[holder] && (cnt < CNT_MAX)) begin
          cnt_nxt = cnt + CNT_ONE;
        end else begin
          // Release: a drop of req[holder] and a timeout are handled alike.
          ptr_nxt = holder + idx_t'(1);
          if (pick_found) begin
            gnt_nxt = idx_to_onehot(pick_index);
            sel_nxt = idx_to_sel(pick_index);
            cnt_nxt = CNT_ONE;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            sel_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      sel   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
    end
  end

  assign busy = |gnt;
  assign s0   = sel.s0;
  assign s1   = sel.s1;

  // Data register samples the mux output selected by the current grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d       <= 1'b0;
      d_valid <= 1'b0;
    end else begin
      d       <= busy ? din[holder] : 1'b0;
      d_valid <= busy;
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] din = '0;

  logic [3:0] gnt_a, gnt_b;
  logic       s0_a, s1_a, busy_a, d_a, dv_a;
  logic       s0_b, s1_b, busy_b, d_b, dv_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance 0: HOLD_MAX=2, instance 1: HOLD_MAX=3.
  rr_mux_arbiter #(.HOLD_MAX(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .din(din),
    .gnt(gnt_a), .s0(s0_a), .s1(s1_a), .busy(busy_a), .d(d_a), .d_valid(dv_a)
  );

  rr_mux_arbiter #(.HOLD_MAX(3)) dut_b (
    .clk(clk), .reset(reset), .req(req), .din(din),
    .gnt(gnt_b), .s0(s0_b), .s1(s1_b), .busy(busy_b), .d(d_b), .d_valid(dv_b)
  );

  // ---------------- reference model (holder / count / pointer) -------------
  int   hm[2] = '{2, 3};
  int   m_hold[2];   // -1 when nobody holds the grant
  int   m_cnt[2];
  int   m_ptr[2];
  logic m_d[2];
  logic m_dv[2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_hold[i] = -1; m_cnt[i] = 0; m_ptr[i] = 0; m_d[i] = 1'b0; m_dv[i] = 1'b0;
    end
  endfunction

  function automatic void model_search(int i, logic [3:0] r, int from);
    m_hold[i] = -1;
    m_cnt[i]  = 0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (from + k) % 4;
      if (r[c] && m_hold[i] < 0) begin
        m_hold[i] = c;
        m_cnt[i]  = 1;
      end
    end
  endfunction

  function automatic void model_step(int i, logic [3:0] r, logic [3:0] dn);
    m_d[i]  = (m_hold[i] >= 0) ? dn[m_hold[i]] : 1'b0;
    m_dv[i] = (m_hold[i] >= 0);
    if (m_hold[i] < 0) begin
      model_search(i, r, m_ptr[i]);
    end else if (r[m_hold[i]] && m_cnt[i] < hm[i]) begin
      m_cnt[i]++;
    end else begin
      m_ptr[i] = (m_hold[i] + 1) % 4;
      model_search(i, r, m_ptr[i]);
    end
  endfunction

  function automatic logic [3:0] exp_gnt(int i);
    return (m_hold[i] < 0) ? 4'b0000 : 4'(1 << m_hold[i]);
  endfunction

  function automatic logic [1:0] exp_sel(int i);
    return (m_hold[i] < 0) ? 2'b00 : 2'(m_hold[i]);
  endfunction

  // ---------------- DUT observation accessors ------------------------------
  function automatic logic [3:0] act_gnt(int i);
    return (i == 0) ? gnt_a : gnt_b;
  endfunction
  function automatic logic [1:0] act_sel(int i);
    return (i == 0) ? {s0_a, s1_a} : {s0_b, s1_b};
  endfunction
  function automatic logic act_busy(int i);
    return (i == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic act_d(int i);
    return (i == 0) ? d_a : d_b;
  endfunction
  function automatic logic act_dv(int i);
    return (i == 0) ? dv_a : dv_b;
  endfunction
  function automatic int act_cnt(int i);
    return (i == 0) ? int'(dut_a.cnt) : int'(dut_b.cnt);
  endfunction

  // Drive one cycle (called 1 time unit after a rising edge), advance the
  // models, and return 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] dn);
    req = r;
    din = dn;
    for (int i = 0; i < 2; i++) model_step(i, r, dn);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b0000 || act_sel(i) !== 2'b00 || act_busy(i) !== 1'b0 ||
          act_d(i) !== 1'b0 || act_dv(i) !== 1'b0 || act_cnt(i) !== 0) begin
        errors++;
        $display("FAIL reset_state inst=%0d gnt=%b sel=%b busy=%b d=%b dv=%b cnt=%0d expected all zero",
                 i, act_gnt(i), act_sel(i), act_busy(i), act_d(i), act_dv(i), act_cnt(i));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    step(4'b0010, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b0010 || act_sel(i) !== 2'b01 || act_busy(i) !== 1'b1) begin
        errors++;
        $display("FAIL single_grant inst=%0d gnt=%b sel=%b busy=%b expected 0010 01 1",
                 i, act_gnt(i), act_sel(i), act_busy(i));
      end
    end
    step(4'b0000, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b0000 || act_d(i) !== 1'b1 || act_dv(i) !== 1'b1) begin
        errors++;
        $display("FAIL single_release inst=%0d gnt=%b d=%b dv=%b expected 0000 1 1",
                 i, act_gnt(i), act_d(i), act_dv(i));
      end
    end
    step(4'b0000, 4'b0010);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_dv(i) !== 1'b0) begin
        errors++;
        $display("FAIL single_dv_drop inst=%0d dv=%b expected 0", i, act_dv(i));
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                4'b0100, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(4'b1111, 4'($urandom_range(0, 15)));
      checks++;
      if (gnt_a !== exp_seq[k] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL fairness_h2 edge=%0d gnt=%b busy=%b expected %b 1",
                 k, gnt_a, busy_a, exp_seq[k]);
      end
      checks++;
      if (gnt_b !== exp_gnt(1) || act_d(1) !== m_d[1]) begin
        errors++;
        $display("FAIL fairness_h3 edge=%0d gnt=%b d=%b expected %b %b",
                 k, gnt_b, d_b, exp_gnt(1), m_d[1]);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step(4'b1000, 4'b1000);
      checks++;
      if (gnt_b !== 4'b1000 || busy_b !== 1'b1 || act_cnt(1) !== (k % 3) + 1 ||
          {s0_b, s1_b} !== 2'b11) begin
        errors++;
        $display("FAIL timeout_regrant edge=%0d gnt=%b busy=%b cnt=%0d sel=%b expected 1000 1 %0d 11",
                 k, gnt_b, busy_b, act_cnt(1), {s0_b, s1_b}, (k % 3) + 1);
      end
    end
  endtask

  task automatic test_handoff();
    do_reset();
    step(4'b0010, 4'b0000);
    step(4'b1011, 4'b0000);
    step(4'b1001, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b1000 || act_sel(i) !== 2'b11 || act_busy(i) !== 1'b1) begin
        errors++;
        $display("FAIL handoff inst=%0d gnt=%b sel=%b busy=%b expected 1000 11 1",
                 i, act_gnt(i), act_sel(i), act_busy(i));
      end
    end
  endtask

  task automatic test_data_mapping();
    logic [3:0] dv_pat;
    dv_pat = 4'b1010;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'(1 << k), dv_pat);
      checks++;
      if (gnt_b !== 4'(1 << k) || {s0_b, s1_b} !== 2'(k)) begin
        errors++;
        $display("FAIL data_grant idx=%0d gnt=%b sel=%b expected %b %b",
                 k, gnt_b, {s0_b, s1_b}, 4'(1 << k), 2'(k));
      end
      step(4'b0000, dv_pat);
      checks++;
      if (d_b !== dv_pat[k] || dv_b !== 1'b1) begin
        errors++;
        $display("FAIL data_map idx=%0d d=%b dv=%b expected %b 1", k, d_b, dv_b, dv_pat[k]);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    step(4'b0100, 4'b0100);
    checks++;
    if (gnt_b !== 4'b0100 || act_cnt(1) !== 3) begin
      errors++;
      $display("FAIL mid_grant_setup gnt=%b cnt=%0d expected 0100 3", gnt_b, act_cnt(1));
    end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b0000 || act_sel(i) !== 2'b00 || act_busy(i) !== 1'b0 ||
          act_dv(i) !== 1'b0 || act_d(i) !== 1'b0) begin
        errors++;
        $display("FAIL async_reset inst=%0d gnt=%b sel=%b busy=%b dv=%b d=%b expected all zero",
                 i, act_gnt(i), act_sel(i), act_busy(i), act_dv(i), act_d(i));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(4'b0100, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (act_gnt(i) !== 4'b0100 || act_sel(i) !== 2'b10) begin
        errors++;
        $display("FAIL regrant_after_reset inst=%0d gnt=%b sel=%b expected 0100 10",
                 i, act_gnt(i), act_sel(i));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0) r = r ^ 4'(1 << $urandom_range(0, 3));
      step(r, 4'($urandom_range(0, 15)));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (act_gnt(i) !== exp_gnt(i) || act_sel(i) !== exp_sel(i) ||
            act_busy(i) !== (m_hold[i] >= 0) || act_cnt(i) !== m_cnt[i] ||
            act_d(i) !== m_d[i] || act_dv(i) !== m_dv[i]) begin
          errors++;
          $display("FAIL random cyc=%0d inst=%0d req=%b gnt=%b/%b sel=%b/%b cnt=%0d/%0d d=%b/%b dv=%b/%b (actual/expected)",
                   n, i, r, act_gnt(i), exp_gnt(i), act_sel(i), exp_sel(i),
                   act_cnt(i), m_cnt[i], act_d(i), m_d[i], act_dv(i), m_dv[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_handoff();
    test_data_mapping();
    test_reset_mid_grant();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
